// File: rtl/game_state_controller.sv
// Game flow controller: debounces the menu buttons, selects mode and difficulty,
// runs the start countdown, gates play and waits for btnC release before the menu.
module game_state_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICKS_PER_SEC   = 100000000,
    parameter int COUNTDOWN_SECS  = 3
) (
    input  logic       clock_100mhz,
    input  logic       rst_n,
    input  logic       btnC,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       return_to_menu,
    output logic       game_active,
    output logic       mode,
    output logic       difficulty,
    output logic       cursor,
    output logic [2:0] state_code,
    output logic [1:0] countdown_value
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [1:0]    CD_LOAD   = 2'(COUNTDOWN_SECS);

    typedef enum logic [2:0] {
        MENU_MODE    = 3'd0,
        MENU_DIFF    = 3'd1,
        COUNTDOWN    = 3'd2,
        PLAYING      = 3'd3,
        RELEASE_WAIT = 3'd4
    } state_t;

    // Button lanes: bit 0 = C, bit 1 = U, bit 2 = D
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    level;
    logic [2:0]    level_q;
    logic [2:0]    press;
    logic [DW-1:0] db_cnt [3];

    assign raw   = {btnD, btnU, btnC};
    assign press = level & ~level_q;

    always_ff @(posedge clock_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        level[i]  <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    state_t        state, state_n;
    logic          mode_n, difficulty_n, cursor_n;
    logic [1:0]    cd_n;
    logic [TW-1:0] tick, tick_n;
    logic          up_only, down_only, selected;

    // Conflicting U/D pulses cancel; the surviving one feeds a same-cycle C confirm
    assign up_only   = press[1] & ~press[2];
    assign down_only = press[2] & ~press[1];

    always_comb begin
        selected = cursor;
        if (up_only)   selected = 1'b0;
        if (down_only) selected = 1'b1;
    end

    always_comb begin
        state_n      = state;
        mode_n       = mode;
        difficulty_n = difficulty;
        cursor_n     = cursor;
        cd_n         = countdown_value;
        tick_n       = tick;
        case (state)
            MENU_MODE: begin
                cursor_n = selected;
                if (press[0]) begin
                    mode_n   = selected;
                    cursor_n = difficulty;
                    state_n  = MENU_DIFF;
                end
            end
            MENU_DIFF: begin
                cursor_n = selected;
                if (press[0]) begin
                    difficulty_n = selected;
                    cd_n         = CD_LOAD;
                    tick_n       = '0;
                    state_n      = COUNTDOWN;
                end
            end
            COUNTDOWN: begin
                if (tick == TICK_LAST) begin
                    tick_n = '0;
                    if (countdown_value <= 2'd1) begin
                        cd_n    = 2'd0;
                        state_n = PLAYING;
                    end else begin
                        cd_n = countdown_value - 2'd1;
                    end
                end else begin
                    tick_n = tick + TW'(1);
                end
            end
            PLAYING: begin
                if (return_to_menu) state_n = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                // Leaving only after release means the game-ending press never confirms a menu
                if (!level[0]) begin
                    cursor_n = mode;
                    state_n  = MENU_MODE;
                end
            end
            default: state_n = MENU_MODE;
        endcase
    end

    always_ff @(posedge clock_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state           <= MENU_MODE;
            mode            <= 1'b0;
            difficulty      <= 1'b0;
            cursor          <= 1'b0;
            countdown_value <= 2'd0;
            tick            <= '0;
        end else begin
            state           <= state_n;
            mode            <= mode_n;
            difficulty      <= difficulty_n;
            cursor          <= cursor_n;
            countdown_value <= cd_n;
            tick            <= tick_n;
        end
    end

    assign game_active = (state == PLAYING);
    assign state_code  = state;

endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
- Top-level game flow FSM; sits directly upstream of the game logic block.
- Drives game_active, mode and difficulty into the game logic block and consumes its return_to_menu flag.
- Debounces the three menu buttons, runs mode and difficulty selection, then a start countdown, then play.
- After play, returns to the menu without letting the btnC press that ended the game be reused as a menu confirm.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz)
TICKS_PER_SEC, 100000000, clock cycles per countdown second
COUNTDOWN_SECS, 3, countdown length in seconds (1..3)

Ports:
clock_100mhz  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
btnC  input  1  raw centre button, confirm
btnU  input  1  raw up button, selects value 0
btnD  input  1  raw down button, selects value 1
return_to_menu  input  1  level from game logic block, high once the game ends and btnC is pressed
game_active  output  1  high only in PLAYING
mode  output  1  latched mode selection
difficulty  output  1  latched difficulty selection
cursor  output  1  value currently highlighted in the active menu
state_code  output  3  0=MENU_MODE, 1=MENU_DIFF, 2=COUNTDOWN, 3=PLAYING, 4=RELEASE_WAIT
countdown_value  output  2  seconds remaining; 0 outside COUNTDOWN

Behaviour:
Reset (async, rst_n=0):
- All outputs are 0; state is MENU_MODE.
- Debounce counters, synchronisers, debounced levels and timers are cleared.
- Reset in any state, including PLAYING, returns to MENU_MODE immediately.

Debounce, per button:
- 2-flop synchroniser, then a counter.
- The debounced level flips when the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
- A press pulse is one cycle wide, on the 0->1 edge of the debounced level.

Simultaneous events:
- U and D pulses in the same cycle: both ignored.
- C together with U or D: U/D updates cursor first, then C confirms the updated value in the same cycle.

MENU_MODE:
- U pulse sets cursor=0; D pulse sets cursor=1.
- C pulse: mode<=cursor, cursor<=difficulty (the previous selection), go to MENU_DIFF next cycle.

MENU_DIFF:
- U and D as in MENU_MODE.
- C pulse: difficulty<=cursor; load countdown_value=COUNTDOWN_SECS; clear tick counter; go to COUNTDOWN.

COUNTDOWN:
- Tick counter counts 0..TICKS_PER_SEC-1.
- At the wrap, countdown_value decrements.
- In the cycle countdown_value would go 1->0: go to PLAYING, countdown_value=0.
- All button pulses are ignored.

PLAYING:
- game_active=1 from the first cycle in the state.
- return_to_menu sampled high: next cycle go to RELEASE_WAIT with game_active=0.
- Buttons are ignored (btnC belongs to the game logic block here).

RELEASE_WAIT:
- game_active=0; the game logic block clears return_to_menu once it sees this.
- Stay until the debounced btnC level is 0; then go to MENU_MODE with cursor<=mode.
- A C pulse cannot be generated until a new press after the release, so no spurious confirm.

Other rules:
- mode and difficulty hold their values outside their menu states, including through PLAYING.
- return_to_menu is ignored outside PLAYING.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, TICKS_PER_SEC=10, COUNTDOWN_SECS=3.)
- Debounce: btnD toggled every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one D pulse, 4 stable cycles plus 2 synchroniser cycles after the final rise; cursor 0->1 once.
- Menu flow: D, C, U, C presses -> mode=1, difficulty=0, state_code 0->1->2. countdown_value reads 3, then 2 after 10 cycles, then 1, then PLAYING at cycle 30 with game_active=1.
- Simultaneous: U and D asserted on the same cycle, held 8 cycles -> no cursor change; then C+D together in MENU_MODE -> mode=1.
- Return: in PLAYING, btnC held high and return_to_menu raised -> game_active=0 next cycle, state_code=4. Stays 4 while btnC held 50 cycles; after release plus debounce -> state_code=0, no confirm, cursor=mode.
- Reset: rst_n pulled low mid-COUNTDOWN (countdown_value=2) and mid-PLAYING -> all outputs 0 asynchronously, without waiting for a clock edge; state_code=0.
- Ignore rules: return_to_menu high in MENU_MODE, and button presses during COUNTDOWN -> no state, mode or difficulty change.
